// File: rtl/i3c_bus_access_arbiter.sv
// Shares a wired-AND I3C bus between NumReq agents by watching START/STOP and issuing one-hot grants.
// Optional build macro I3C_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module i3c_bus_access_arbiter #(
  parameter int NumReq        = 3,
  parameter int BusFreeCycles = 8,
  parameter int BusIdleCycles = 64,
  parameter int GrantTimeout  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  input  logic [NumReq-1:0]         req_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      bus_free_o,
  output logic                      busy_o,
  output logic                      foreign_start_o,
  output logic                      timeout_o
);

  localparam int OwnW   = $clog2(NumReq);
  localparam int OwnW1  = OwnW + 1;
  localparam int CntMax = (BusFreeCycles > BusIdleCycles) ? BusFreeCycles : BusIdleCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int TmrW   = $clog2(GrantTimeout + 1);
  localparam logic [NumReq-1:0] OneHotLsb = NumReq'(1);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_WAIT_FREE = 3'd1,
    ST_FREE      = 3'd2,
    ST_GRANT     = 3'd3,
    ST_OWNED     = 3'd4,
    ST_BUSY      = 3'd5
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [1:0]        scl_sync_r;
  logic [1:0]        sda_sync_r;
  logic              scl_hist_r;
  logic              sda_hist_r;
  logic              start_det_s;
  logic              stop_det_s;
  logic              start_s;
  logic              stop_s;
  logic [CntW-1:0]   free_cnt_r;
  logic [CntW-1:0]   free_cnt_inc_s;
  logic [TmrW-1:0]   timer_r;
  logic [OwnW-1:0]   owner_r;
  logic [OwnW-1:0]   owner_nxt_s;
  logic [OwnW-1:0]   sel_s;
  logic              sel_vld_s;
  logic              grant_s;
  logic              foreign_s;
  logic              timeout_s;
  logic [NumReq-1:0] gnt_nxt_s;
  logic              bus_free_nxt_s;
  logic              busy_nxt_s;
  logic [NumReq-1:0] gnt_r;
  logic              bus_free_r;
  logic              busy_r;
  logic              foreign_r;
  logic              timeout_r;

  // Synchronizer and history flops; reset to the idle-high bus level so no edge is invented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_i};
      sda_sync_r <= {sda_sync_r[0], sda_i};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign start_det_s = scl_sync_r[1] & scl_hist_r & sda_hist_r & ~sda_sync_r[1];
  assign stop_det_s  = scl_sync_r[1] & scl_hist_r & ~sda_hist_r & sda_sync_r[1];
  // STOP dominates should both detectors ever fire together.
  assign start_s     = start_det_s & ~stop_det_s;
  assign stop_s      = stop_det_s;

  // Saturating idle-high counter value for this cycle.
  always_comb begin
    free_cnt_inc_s = CntW'(0);
    if (scl_sync_r[1] && sda_sync_r[1]) begin
      if (free_cnt_r >= CntW'(CntMax)) begin
        free_cnt_inc_s = free_cnt_r;
      end else begin
        free_cnt_inc_s = free_cnt_r + CntW'(1);
      end
    end else begin
      free_cnt_inc_s = CntW'(0);
    end
  end

`ifdef I3C_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning downward lets the lowest asserted index win.
  always_comb begin
    sel_s     = OwnW'(0);
    sel_vld_s = |req_i;
    for (int i = NumReq - 1; i >= 0; i--) begin
      sel_s = req_i[i] ? OwnW'(i) : sel_s;
    end
  end
`else
  logic [OwnW-1:0]  rr_ptr_r;
  logic [OwnW1-1:0] cand_s;

  function automatic logic [OwnW-1:0] wrap_inc(input logic [OwnW-1:0] v);
    return (v == OwnW'(NumReq - 1)) ? OwnW'(0) : v + OwnW'(1);
  endfunction

  // Round-robin: first asserted request at or after the pointer, wrapping.
  always_comb begin
    sel_s     = OwnW'(0);
    sel_vld_s = 1'b0;
    cand_s    = OwnW1'(0);
    for (int i = 0; i < NumReq; i++) begin
      cand_s    = {1'b0, rr_ptr_r} + OwnW1'(i);
      cand_s    = (cand_s >= OwnW1'(NumReq)) ? cand_s - OwnW1'(NumReq) : cand_s;
      sel_s     = (!sel_vld_s && req_i[cand_s[OwnW-1:0]]) ? cand_s[OwnW-1:0] : sel_s;
      sel_vld_s = sel_vld_s | req_i[cand_s[OwnW-1:0]];
    end
  end

  // Round-robin pointer moves past the owner on every grant and on every timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r <= OwnW'(0);
    end else if (grant_s) begin
      rr_ptr_r <= wrap_inc(sel_s);
    end else if (timeout_s) begin
      rr_ptr_r <= wrap_inc(owner_r);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a START always beats a grant that would issue in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    foreign_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
        end else if (free_cnt_inc_s >= CntW'(BusIdleCycles)) begin
          state_nxt_s = ST_FREE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_WAIT_FREE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
        end else if (free_cnt_inc_s >= CntW'(BusFreeCycles)) begin
          state_nxt_s = ST_FREE;
        end else begin
          state_nxt_s = ST_WAIT_FREE;
        end
      end
      ST_FREE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
          foreign_s   = 1'b1;
        end else if (sel_vld_s) begin
          state_nxt_s = ST_GRANT;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      ST_GRANT: begin
        if (start_s) begin
          state_nxt_s = ST_OWNED;
        end else if (!req_i[owner_r]) begin
          state_nxt_s = ST_FREE;
        end else if (timer_r >= TmrW'(GrantTimeout - 1)) begin
          state_nxt_s = ST_FREE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_OWNED: begin
        if (stop_s) begin
          state_nxt_s = ST_WAIT_FREE;
        end else begin
          state_nxt_s = ST_OWNED;
        end
      end
      ST_BUSY: begin
        if (stop_s) begin
          state_nxt_s = ST_WAIT_FREE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Free counter restarts on entry to WAIT_FREE; grant timer runs only while parked in GRANT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_cnt_r <= CntW'(0);
      timer_r    <= TmrW'(0);
      owner_r    <= OwnW'(0);
    end else begin
      free_cnt_r <= (state_nxt_s == ST_WAIT_FREE && state_r != ST_WAIT_FREE) ? CntW'(0) : free_cnt_inc_s;
      timer_r    <= (state_nxt_s == ST_GRANT && state_r == ST_GRANT) ? timer_r + TmrW'(1) : TmrW'(0);
      owner_r    <= owner_nxt_s;
    end
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    owner_nxt_s    = grant_s ? sel_s : owner_r;
    gnt_nxt_s      = NumReq'(0);
    bus_free_nxt_s = (state_nxt_s == ST_FREE) || (state_nxt_s == ST_GRANT);
    busy_nxt_s     = (state_nxt_s == ST_OWNED) || (state_nxt_s == ST_BUSY);
    if (state_nxt_s == ST_GRANT || state_nxt_s == ST_OWNED) begin
      gnt_nxt_s = OneHotLsb << owner_nxt_s;
    end else begin
      gnt_nxt_s = NumReq'(0);
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_r      <= NumReq'(0);
      bus_free_r <= 1'b0;
      busy_r     <= 1'b0;
      foreign_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      gnt_r      <= gnt_nxt_s;
      bus_free_r <= bus_free_nxt_s;
      busy_r     <= busy_nxt_s;
      foreign_r  <= foreign_s;
      timeout_r  <= timeout_s;
    end
  end

  assign gnt_o           = gnt_r;
  assign owner_o         = owner_r;
  assign bus_free_o      = bus_free_r;
  assign busy_o          = busy_r;
  assign foreign_start_o = foreign_r;
  assign timeout_o       = timeout_r;

endmodule

// File: tb/tb_i3c_bus_access_arbiter.sv
// Scoreboard bench for i3c_bus_access_arbiter: expected grants are queued when requests are driven
// and popped when the DUT raises a grant. Honours I3C_ARB_FIXED_PRIO_EN for ordering expectations.
module tb_i3c_bus_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       bus_free;
  logic       busy;
  logic       foreign_start;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  i3c_bus_access_arbiter #(
    .NumReq(3), .BusFreeCycles(8), .BusIdleCycles(64), .GrantTimeout(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .req_i(req),
    .gnt_o(gnt), .owner_o(owner), .bus_free_o(bus_free), .busy_o(busy),
    .foreign_start_o(foreign_start), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_and_idle();
    rst = 1'b1; scl = 1'b1; sda = 1'b1; req = 3'b000;
    idle(2);
    rst = 1'b0;
    idle(66);
  endtask

  // Waits for a non-zero grant; ok=0 when the cycle budget expires.
  task automatic wait_grant(output logic [2:0] g, output logic [1:0] o, output int n, output bit ok);
    ok = 1'b0; g = 3'b000; o = 2'b00; n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n = i + 1;
      if (gnt !== 3'b000) begin
        g = gnt; o = owner; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start();
    sda = 1'b0; idle(4);
    scl = 1'b0; idle(2);
  endtask

  task automatic data_bits(input int n);
    for (int i = 0; i < n; i++) begin
      scl = 1'b0; sda = 1'($urandom_range(0, 1)); idle(1);
      scl = 1'b1; idle(2);
      scl = 1'b0; idle(1);
    end
  endtask

  task automatic do_stop();
    sda = 1'b0; scl = 1'b0; idle(1);
    scl = 1'b1; idle(2);
    sda = 1'b1; idle(4);
  endtask

  task automatic test_reset();
    logic [2:0] g, e; logic [1:0] o; int n; bit ok;
    rst = 1'b1; scl = 1'b1; sda = 1'b1; req = 3'b000;
    idle(2);
    checks++;
    if ({gnt, owner, bus_free, busy, foreign_start, timeout} !== 9'b0) begin
      failures++; $display("FAIL reset_values got=%b expected=%b", {gnt, owner, bus_free, busy, foreign_start, timeout}, 9'b0);
    end
    rst = 1'b0;
    idle(63);
    checks++;
    if (bus_free !== 1'b0) begin failures++; $display("FAIL bus_free_early got=%b expected=0", bus_free); end
    idle(1);
    checks++;
    if (bus_free !== 1'b1) begin failures++; $display("FAIL bus_free_at_64 got=%b expected=1", bus_free); end
    req = 3'b001; exp_q.push_back(3'b001);
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e || n != 1 || bus_free !== 1'b1) begin
      failures++; $display("FAIL first_grant gnt=%b cycles=%0d bus_free=%b expected gnt=%b cycles=1 bus_free=1", g, n, bus_free, e);
    end
    req = 3'b000; idle(3);
    checks++;
    if (gnt !== 3'b000 || bus_free !== 1'b1) begin
      failures++; $display("FAIL grant_drop gnt=%b bus_free=%b expected gnt=000 bus_free=1", gnt, bus_free);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g, e; logic [1:0] o; int n; bit ok;
    reset_and_idle();
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
`ifdef I3C_ARB_FIXED_PRIO_EN
      exp_q.push_back(3'b001);
`else
      exp_q.push_back(3'b001 << k);
`endif
      wait_grant(g, o, n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g !== e || o !== 2'(idx_of(e))) begin
        failures++; $display("FAIL rr_grant%0d gnt=%b owner=%0d expected gnt=%b owner=%0d", k, g, o, e, idx_of(e));
      end
      do_start();
      checks++;
      if (busy !== 1'b1 || gnt !== e) begin
        failures++; $display("FAIL rr_owned%0d busy=%b gnt=%b expected busy=1 gnt=%b", k, busy, gnt, e);
      end
      data_bits(2);
      do_stop();
      checks++;
      if (busy !== 1'b0 || gnt !== 3'b000) begin
        failures++; $display("FAIL rr_stop%0d busy=%b gnt=%b expected busy=0 gnt=000", k, busy, gnt);
      end
    end
    req = 3'b000; idle(12);
  endtask

  task automatic test_timeout();
    logic [2:0] g, e; logic [1:0] o; int n, t; bit ok, seen;
    reset_and_idle();
    req = 3'b010; exp_q.push_back(3'b010);
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin failures++; $display("FAIL to_grant gnt=%b expected=%b", g, e); end
    req = 3'b111;
    seen = 1'b0; t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      t = i + 1;
      if (timeout === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || t < 31 || t > 33 || gnt !== 3'b000) begin
      failures++; $display("FAIL to_pulse seen=%b cycles=%0d gnt=%b expected seen=1 cycles=32 gnt=000", seen, t, gnt);
    end
    idle(1);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL to_width got=%b expected=0", timeout); end
`ifdef I3C_ARB_FIXED_PRIO_EN
    exp_q.push_back(3'b001);
`else
    exp_q.push_back(3'b100);
`endif
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin failures++; $display("FAIL to_next_grant gnt=%b expected=%b", g, e); end
    req = 3'b000; idle(3);
  endtask

  task automatic test_foreign();
    int fcnt, m; bit ok;
    reset_and_idle();
    sda = 1'b0; fcnt = 0;
    repeat (6) begin @(negedge clk); fcnt += int'(foreign_start); end
    checks++;
    if (fcnt != 1 || busy !== 1'b1 || gnt !== 3'b000) begin
      failures++; $display("FAIL foreign_pulse pulses=%0d busy=%b gnt=%b expected pulses=1 busy=1 gnt=000", fcnt, busy, gnt);
    end
    scl = 1'b0; data_bits(2);
    checks++;
    if (busy !== 1'b1 || gnt !== 3'b000) begin
      failures++; $display("FAIL foreign_hold busy=%b gnt=%b expected busy=1 gnt=000", busy, gnt);
    end
    sda = 1'b0; scl = 1'b0; idle(1); scl = 1'b1; idle(2); sda = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy === 1'b0) begin ok = 1'b1; break; end end
    m = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); m = i + 1; if (bus_free === 1'b1) break; end
    checks++;
    if (!ok || m != 8 || bus_free !== 1'b1) begin
      failures++; $display("FAIL foreign_free stop_seen=%b cycles=%0d expected stop_seen=1 cycles=8", ok, m);
    end
  endtask

  task automatic test_start_vs_grant();
    reset_and_idle();
    sda = 1'b0; idle(2);
    req = 3'b001; idle(1);
    checks++;
    if (foreign_start !== 1'b1 || busy !== 1'b1 || gnt !== 3'b000) begin
      failures++; $display("FAIL start_wins foreign=%b busy=%b gnt=%b expected foreign=1 busy=1 gnt=000", foreign_start, busy, gnt);
    end
    idle(3);
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL start_wins_hold gnt=%b expected=000", gnt); end
    req = 3'b000;
    do_stop(); idle(12);
  endtask

  task automatic test_owned_drop();
    logic [2:0] g, e; logic [1:0] o; int n; bit ok;
    reset_and_idle();
    req = 3'b001; exp_q.push_back(3'b001);
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e) begin failures++; $display("FAIL own_grant gnt=%b expected=%b", g, e); end
    do_start();
    req = 3'b000; idle(4); data_bits(1);
    checks++;
    if (gnt !== 3'b001 || busy !== 1'b1) begin
      failures++; $display("FAIL own_hold gnt=%b busy=%b expected gnt=001 busy=1", gnt, busy);
    end
    do_stop();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || bus_free !== 1'b0) begin
      failures++; $display("FAIL own_release gnt=%b busy=%b bus_free=%b expected 000 0 0", gnt, busy, bus_free);
    end
    idle(12);
  endtask

  task automatic test_reset_mid();
    logic [2:0] g, e; logic [1:0] o; int n; bit ok, early;
    reset_and_idle();
    req = 3'b001; exp_q.push_back(3'b001);
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    do_start();
    checks++;
    if (!ok || g !== e || busy !== 1'b1) begin
      failures++; $display("FAIL rmid_owned gnt=%b busy=%b expected gnt=%b busy=1", g, busy, e);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, owner, bus_free, busy, foreign_start, timeout} !== 9'b0) begin
      failures++; $display("FAIL rmid_async got=%b expected=%b", {gnt, owner, bus_free, busy, foreign_start, timeout}, 9'b0);
    end
    scl = 1'b1; sda = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin @(negedge clk); if (gnt !== 3'b000) early = 1'b1; end
    checks++;
    if (early) begin failures++; $display("FAIL rmid_early_grant got=1 expected=0"); end
    exp_q.push_back(3'b001);
    wait_grant(g, o, n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g !== e || n != 2) begin
      failures++; $display("FAIL rmid_regrant gnt=%b cycles=%0d expected gnt=%b cycles=2", g, n, e);
    end
    req = 3'b000; idle(3);
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda = 1'b1; req = 3'b000;
    test_reset();
    test_round_robin();
    test_timeout();
    test_foreign();
    test_start_vs_grant();
    test_owned_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
